// File: rtl/d_f_f_bank_if.sv
// d_f_f_bank control/status bundle.
// Master drives the operation inputs; slave is the register bank.
interface d_f_f_bank_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d_in;
    logic             ser_in;
    logic [WIDTH-1:0] q_out;
    logic [WIDTH-1:0] qb_out;
    logic [WIDTH-1:0] q_dly;
    logic             dly_vld;
    logic             chg;
    logic [15:0]      upd_cnt;

    modport master (
        output en, mode, d_in, ser_in,
        input  q_out, qb_out, q_dly, dly_vld, chg, upd_cnt
    );

    modport slave (
        input  en, mode, d_in, ser_in,
        output q_out, qb_out, q_dly, dly_vld, chg, upd_cnt
    );
endinterface

// File: rtl/d_f_f_bank.sv
// d_f_f_bank: multi-mode register bank with delayed copy
// and change-detect status.
module d_f_f_bank #(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input logic        clk,
    input logic        rs,
    d_f_f_bank_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] nq;
    logic [WIDTH-1:0] shl;
    logic [WIDTH-1:0] shr;
    logic [WIDTH-1:0] rol;
    logic [WIDTH-1:0] stg [DEPTH];
    logic [CW-1:0]    fill;
    logic             chg_r;
    logic [15:0]      cnt;

    // A single-bit bank has nothing to shift past: shifts take
    // the serial bit and rotate is a no-op.
    generate
        if (WIDTH == 1) begin : g_w1
            assign shl = bus.ser_in;
            assign shr = bus.ser_in;
            assign rol = q;
        end else begin : g_wn
            assign shl = {q[WIDTH-2:0], bus.ser_in};
            assign shr = {bus.ser_in, q[WIDTH-1:1]};
            assign rol = {q[WIDTH-2:0], q[WIDTH-1]};
        end
    endgenerate

    // Next-state decode; every mode code is covered.
    always_comb begin
        nq = q;
        if (bus.en) begin
            unique case (bus.mode)
                3'b000: nq = q;
                3'b001: nq = bus.d_in;
                3'b010: nq = q ^ bus.d_in;
                3'b011: nq = shl;
                3'b100: nq = shr;
                3'b101: nq = rol;
                3'b110: nq = q | bus.d_in;
                3'b111: nq = q & ~bus.d_in;
            endcase
        end
    end

    // Bank state plus change flag and saturating change count.
    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            q     <= RST_VAL;
            chg_r <= 1'b0;
            cnt   <= '0;
        end else begin
            q     <= nq;
            chg_r <= (nq != q);
            if ((nq != q) && (cnt != 16'hFFFF))
                cnt <= cnt + 16'd1;
        end
    end

    // Delay line captures the pre-edge bank value; fill counter
    // qualifies the output once every stage holds real data.
    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            for (int i = 0; i < DEPTH; i++)
                stg[i] <= RST_VAL;
            fill <= '0;
        end else begin
            stg[0] <= q;
            for (int i = 1; i < DEPTH; i++)
                stg[i] <= stg[i-1];
            if (fill != CW'(DEPTH))
                fill <= fill + 1'b1;
        end
    end

    assign bus.q_out   = q;
    assign bus.qb_out  = ~q;
    assign bus.q_dly   = stg[DEPTH-1];
    assign bus.dly_vld = (fill == CW'(DEPTH));
    assign bus.chg     = chg_r;
    assign bus.upd_cnt = cnt;
endmodule

// File: tb/tb_d_f_f_bank.sv
// Directed-vector bench for d_f_f_bank: 8-bit/depth-2,
// 8-bit/depth-4 and 1-bit builds side by side.
module tb_d_f_f_bank;
    logic clk = 1'b0;
    logic rs8 = 1'b0;
    logic rs4 = 1'b0;
    logic rs1 = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    d_f_f_bank_if #(.WIDTH(8)) b8 ();
    d_f_f_bank_if #(.WIDTH(8)) b4 ();
    d_f_f_bank_if #(.WIDTH(1)) b1 ();

    d_f_f_bank #(.WIDTH(8), .DEPTH(2), .RST_VAL(8'h00)) u8 (
        .clk(clk), .rs(rs8), .bus(b8)
    );
    d_f_f_bank #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'h00)) u4 (
        .clk(clk), .rs(rs4), .bus(b4)
    );
    d_f_f_bank #(.WIDTH(1), .DEPTH(2), .RST_VAL(1'b0)) u1 (
        .clk(clk), .rs(rs1), .bus(b1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        @(negedge clk);
        rs8 = 1'b1;
        b8.en = 1'b1; b8.mode = 3'b001; b8.d_in = 8'h5A;
        repeat (3) tick();
        n_chk++; if (b8.q_out !== 8'h5A) begin n_fail++; $display("FAIL pre_rst_q got %h exp 5a", b8.q_out); end
        n_chk++; if (b8.dly_vld !== 1'b1) begin n_fail++; $display("FAIL pre_rst_vld got %b exp 1", b8.dly_vld); end
        #2 rs8 = 1'b0;
        #1;
        n_chk++; if (b8.q_out !== 8'h00) begin n_fail++; $display("FAIL rst_q got %h exp 00", b8.q_out); end
        n_chk++; if (b8.qb_out !== 8'hFF) begin n_fail++; $display("FAIL rst_qb got %h exp ff", b8.qb_out); end
        n_chk++; if (b8.q_dly !== 8'h00) begin n_fail++; $display("FAIL rst_qdly got %h exp 00", b8.q_dly); end
        n_chk++; if (b8.dly_vld !== 1'b0) begin n_fail++; $display("FAIL rst_vld got %b exp 0", b8.dly_vld); end
        n_chk++; if (b8.chg !== 1'b0) begin n_fail++; $display("FAIL rst_chg got %b exp 0", b8.chg); end
        n_chk++; if (b8.upd_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_cnt got %0d exp 0", b8.upd_cnt); end
        @(negedge clk);
        rs8 = 1'b1;
        b8.en = 1'b1; b8.mode = 3'b001; b8.d_in = 8'hA5;
    endtask

    task automatic test_fill();
        tick();
        n_chk++; if (b8.q_out !== 8'hA5) begin n_fail++; $display("FAIL fill1_q got %h exp a5", b8.q_out); end
        n_chk++; if (b8.dly_vld !== 1'b0) begin n_fail++; $display("FAIL fill1_vld got %b exp 0", b8.dly_vld); end
        n_chk++; if (b8.chg !== 1'b1) begin n_fail++; $display("FAIL fill1_chg got %b exp 1", b8.chg); end
        n_chk++; if (b8.upd_cnt !== 16'd1) begin n_fail++; $display("FAIL fill1_cnt got %0d exp 1", b8.upd_cnt); end
        b8.mode = 3'b000;
        tick();
        n_chk++; if (b8.dly_vld !== 1'b1) begin n_fail++; $display("FAIL fill2_vld got %b exp 1", b8.dly_vld); end
        n_chk++; if (b8.q_dly !== 8'h00) begin n_fail++; $display("FAIL fill2_qdly got %h exp 00", b8.q_dly); end
        n_chk++; if (b8.chg !== 1'b0) begin n_fail++; $display("FAIL fill2_chg got %b exp 0", b8.chg); end
        tick();
        n_chk++; if (b8.q_dly !== 8'hA5) begin n_fail++; $display("FAIL fill3_qdly got %h exp a5", b8.q_dly); end
    endtask

    task automatic test_modes();
        logic [2:0] md [6] = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
        logic [7:0] dv [6] = '{8'h0F, 8'h00, 8'h00, 8'h00, 8'h80, 8'h05};
        logic       sv [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [7:0] ev [6] = '{8'hAA, 8'h55, 8'hAA, 8'h55, 8'hD5, 8'hD0};
        for (int i = 0; i < 6; i++) begin
            b8.mode = md[i]; b8.d_in = dv[i]; b8.ser_in = sv[i];
            tick();
            n_chk++; if (b8.q_out !== ev[i]) begin n_fail++; $display("FAIL mode%0d_q got %h exp %h", md[i], b8.q_out, ev[i]); end
            n_chk++; if (b8.qb_out !== ~ev[i]) begin n_fail++; $display("FAIL mode%0d_qb got %h exp %h", md[i], b8.qb_out, ~ev[i]); end
            n_chk++; if (b8.chg !== 1'b1) begin n_fail++; $display("FAIL mode%0d_chg got %b exp 1", md[i], b8.chg); end
        end
        n_chk++; if (b8.upd_cnt !== 16'd7) begin n_fail++; $display("FAIL modes_cnt got %0d exp 7", b8.upd_cnt); end
    endtask

    task automatic test_enable();
        b8.en = 1'b0; b8.mode = 3'b001; b8.d_in = 8'h3C;
        repeat (3) begin
            tick();
            n_chk++; if (b8.q_out !== 8'hD0) begin n_fail++; $display("FAIL en0_q got %h exp d0", b8.q_out); end
            n_chk++; if (b8.chg !== 1'b0) begin n_fail++; $display("FAIL en0_chg got %b exp 0", b8.chg); end
            n_chk++; if (b8.upd_cnt !== 16'd7) begin n_fail++; $display("FAIL en0_cnt got %0d exp 7", b8.upd_cnt); end
        end
    endtask

    task automatic test_change_count();
        b8.en = 1'b1; b8.mode = 3'b001; b8.d_in = 8'h11;
        tick();
        n_chk++; if (b8.chg !== 1'b1) begin n_fail++; $display("FAIL ld11a_chg got %b exp 1", b8.chg); end
        n_chk++; if (b8.upd_cnt !== 16'd8) begin n_fail++; $display("FAIL ld11a_cnt got %0d exp 8", b8.upd_cnt); end
        tick();
        n_chk++; if (b8.chg !== 1'b0) begin n_fail++; $display("FAIL ld11b_chg got %b exp 0", b8.chg); end
        n_chk++; if (b8.upd_cnt !== 16'd8) begin n_fail++; $display("FAIL ld11b_cnt got %0d exp 8", b8.upd_cnt); end
        b8.d_in = 8'h22;
        tick();
        n_chk++; if (b8.chg !== 1'b1) begin n_fail++; $display("FAIL ld22_chg got %b exp 1", b8.chg); end
        n_chk++; if (b8.upd_cnt !== 16'd9) begin n_fail++; $display("FAIL ld22_cnt got %0d exp 9", b8.upd_cnt); end
    endtask

    task automatic test_saturation();
        b8.mode = 3'b010; b8.d_in = 8'h01;
        repeat (65525) tick();
        n_chk++; if (b8.upd_cnt !== 16'hFFFE) begin n_fail++; $display("FAIL sat_pre got %h exp fffe", b8.upd_cnt); end
        repeat (15) tick();
        n_chk++; if (b8.upd_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_cnt got %h exp ffff", b8.upd_cnt); end
        n_chk++; if (b8.q_out !== 8'h22) begin n_fail++; $display("FAIL sat_q got %h exp 22", b8.q_out); end
        n_chk++; if (b8.chg !== 1'b1) begin n_fail++; $display("FAIL sat_chg got %b exp 1", b8.chg); end
        b8.en = 1'b0;
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        rs4 = 1'b1;
        b4.en = 1'b1; b4.mode = 3'b001; b4.d_in = 8'h01; b4.ser_in = 1'b0;
        tick();
        n_chk++; if (b4.q_out !== 8'h01) begin n_fail++; $display("FAIL ms_ld_q got %h exp 01", b4.q_out); end
        b4.mode = 3'b011;
        repeat (3) tick();
        n_chk++; if (b4.q_out !== 8'h08) begin n_fail++; $display("FAIL ms_shl_q got %h exp 08", b4.q_out); end
        #2 rs4 = 1'b0;
        #1;
        n_chk++; if (b4.q_out !== 8'h00) begin n_fail++; $display("FAIL ms_rst_q got %h exp 00", b4.q_out); end
        n_chk++; if (b4.qb_out !== 8'hFF) begin n_fail++; $display("FAIL ms_rst_qb got %h exp ff", b4.qb_out); end
        n_chk++; if (b4.q_dly !== 8'h00) begin n_fail++; $display("FAIL ms_rst_qdly got %h exp 00", b4.q_dly); end
        n_chk++; if (b4.dly_vld !== 1'b0) begin n_fail++; $display("FAIL ms_rst_vld got %b exp 0", b4.dly_vld); end
        n_chk++; if (b4.chg !== 1'b0) begin n_fail++; $display("FAIL ms_rst_chg got %b exp 0", b4.chg); end
        n_chk++; if (b4.upd_cnt !== 16'd0) begin n_fail++; $display("FAIL ms_rst_cnt got %0d exp 0", b4.upd_cnt); end
        @(negedge clk);
        rs4 = 1'b1;
        b4.ser_in = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_chk++; if (b4.dly_vld !== (k >= 4)) begin n_fail++; $display("FAIL ms_vld_e%0d got %b exp %b", k, b4.dly_vld, (k >= 4)); end
            if (k == 4) begin
                n_chk++; if (b4.q_out !== 8'h0F) begin n_fail++; $display("FAIL ms_e4_q got %h exp 0f", b4.q_out); end
            end
            if (k == 5) begin
                n_chk++; if (b4.q_dly !== 8'h01) begin n_fail++; $display("FAIL ms_e5_qdly got %h exp 01", b4.q_dly); end
            end
        end
    endtask

    task automatic test_width1();
        logic [2:0] md [8] = '{3'b011, 3'b100, 3'b100, 3'b101, 3'b101, 3'b010, 3'b010, 3'b010};
        logic       sv [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic       ev [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        @(negedge clk);
        rs1 = 1'b1;
        b1.en = 1'b1; b1.d_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b1.mode = md[i]; b1.ser_in = sv[i];
            tick();
            n_chk++; if (b1.q_out !== ev[i]) begin n_fail++; $display("FAIL w1_s%0d_q got %b exp %b", i, b1.q_out, ev[i]); end
            n_chk++; if (b1.qb_out !== ~ev[i]) begin n_fail++; $display("FAIL w1_s%0d_qb got %b exp %b", i, b1.qb_out, ~ev[i]); end
        end
        n_chk++; if (b1.upd_cnt !== 16'd6) begin n_fail++; $display("FAIL w1_cnt got %0d exp 6", b1.upd_cnt); end
    endtask

    initial begin
        b8.en = 1'b0; b8.mode = 3'b000; b8.d_in = '0; b8.ser_in = 1'b0;
        b4.en = 1'b0; b4.mode = 3'b000; b4.d_in = '0; b4.ser_in = 1'b0;
        b1.en = 1'b0; b1.mode = 3'b000; b1.d_in = '0; b1.ser_in = 1'b0;
        test_reset();
        test_fill();
        test_modes();
        test_enable();
        test_change_count();
        test_saturation();
        test_reset_midstream();
        test_width1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
